// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: runs the LCD power-on init sequence, then arbitrates
// single-byte writes from two requesters onto one HD44780-style bus.
//
// Request/ack handshake: a requester raises REQn with RSn/DATAn valid and holds
// all three stable until it sees ACKn. ACKn is a one-cycle pulse during the SETUP
// cycle, when RS/DATA have already been latched; later input changes are ignored.
// REQn still high on the cycle after ACKn is a fresh request. Requests are only
// sampled in IDLE once READY=1, so a request raised while BUSY waits, never drops.
module lcd_bus_arbiter #(
   parameter int T_PWR  = 70,
   parameter int T_E    = 4,
   parameter int T_WAIT = 30,
   parameter int T_CLR  = 200
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic       RS0,
   input  logic       RS1,
   input  logic [7:0] DATA0,
   input  logic [7:0] DATA1,
   output logic       ACK0,
   output logic       ACK1,
   output logic       READY,
   output logic       BUSY,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA,
   output logic [2:0] dbg_state
);

   // One counter serves every timed state, so it is sized for the longest one.
   localparam int M_A   = (T_PWR > T_E) ? T_PWR : T_E;
   localparam int M_B   = (T_WAIT > T_CLR) ? T_WAIT : T_CLR;
   localparam int MAX_T = (M_A > M_B) ? M_A : M_B;
   localparam int CW    = $clog2(MAX_T + 1);

   localparam logic [CW-1:0] PWR_LAST  = CW'(T_PWR - 1);
   localparam logic [CW-1:0] E_LAST    = CW'(T_E - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(T_WAIT - 1);
   localparam logic [CW-1:0] CLR_LAST  = CW'(T_CLR - 1);

   // INIT is the setup cycle of each init command; user writes use SETUP.
   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      INIT     = 3'd1,
      IDLE     = 3'd2,
      SETUP    = 3'd3,
      E_HIGH   = 3'd4,
      HOLD     = 3'd5,
      SETTLE   = 3'd6
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     idx_q, idx_d;
   logic           ready_q, ready_d;
   logic           prio_q, prio_d;     // requester that wins a tie
   logic           grant_q, grant_d;   // requester owning the current write
   logic           rs_q, rs_d;
   logic [7:0]     data_q, data_d;
   logic           win;
   logic           is_clr;
   logic [CW-1:0]  settle_last;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = 8'h3C;   // function set
         2'd1:    init_cmd = 8'h0C;   // display on, cursor off
         2'd2:    init_cmd = 8'h06;   // entry mode increment
         default: init_cmd = 8'h01;   // clear display
      endcase
   endfunction

   // Clear and home need the long settle time.
   assign is_clr      = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
   assign settle_last = is_clr ? CLR_LAST : WAIT_LAST;

   // State and datapath registers; reset restarts the whole init sequence.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= PWR_WAIT;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         ready_q <= 1'b0;
         prio_q  <= 1'b0;
         grant_q <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
         prio_q  <= prio_d;
         grant_q <= grant_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
      end
   end

   // Next-state, arbitration and output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      idx_d     = idx_q;
      ready_d   = ready_q;
      prio_d    = prio_q;
      grant_d   = grant_q;
      rs_d      = rs_q;
      data_d    = data_q;
      win       = 1'b0;
      BUSY      = (state_q != IDLE);
      LCD_E     = (state_q == E_HIGH);
      ACK0      = (state_q == SETUP) && !grant_q;
      ACK1      = (state_q == SETUP) && grant_q;
      LCD_RW    = 1'b0;
      LCD_RS    = rs_q;
      LCD_DATA  = data_q;
      READY     = ready_q;
      dbg_state = state_q;

      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == PWR_LAST) begin
               state_d = INIT;
               cnt_d   = '0;
               rs_d    = 1'b0;
               data_d  = init_cmd(idx_q);
            end
         end
         INIT: begin
            state_d = E_HIGH;
            cnt_d   = '0;
         end
         IDLE: begin
            cnt_d = '0;
            if (ready_q && (REQ0 || REQ1)) begin
               // A lone requester always wins; a tie goes to the priority pointer.
               win     = (REQ0 && REQ1) ? prio_q : REQ1;
               grant_d = win;
               prio_d  = !win;
               rs_d    = win ? RS1 : RS0;
               data_d  = win ? DATA1 : DATA0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = E_HIGH;
            cnt_d   = '0;
         end
         E_HIGH: begin
            if (cnt_q == E_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            state_d = SETTLE;
            cnt_d   = '0;
         end
         SETTLE: begin
            if (cnt_q == settle_last) begin
               cnt_d = '0;
               if (ready_q) begin
                  state_d = IDLE;
               end else if (idx_q == 2'd3) begin
                  ready_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  // Next init byte is loaded as this settle ends, never during it.
                  idx_d   = idx_q + 2'd1;
                  data_d  = init_cmd(idx_q + 2'd1);
                  state_d = INIT;
               end
            end
         end
         default: begin
            state_d = PWR_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: timeline model of the LCD arbiter checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_lcd_bus_arbiter;

   localparam int T_PWR   = 70;
   localparam int T_E     = 4;
   localparam int T_WAIT  = 30;
   localparam int T_CLR   = 200;
   localparam int W_NORM  = 2 + T_E + T_WAIT;
   localparam int W_CLR   = 2 + T_E + T_CLR;
   localparam int READY_K = T_PWR + 3 * W_NORM + W_CLR;

   logic       CLK = 1'b0;
   logic       RESETN;
   logic       REQ0, REQ1, RS0, RS1;
   logic [7:0] DATA0, DATA1;
   logic       ACK0, ACK1, READY, BUSY, LCD_E, LCD_RS, LCD_RW;
   logic [7:0] LCD_DATA;
   logic [2:0] dbg_state;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   // clock / reset block
   always #5 CLK = ~CLK;

   lcd_bus_arbiter #(
      .T_PWR (T_PWR),
      .T_E   (T_E),
      .T_WAIT(T_WAIT),
      .T_CLR (T_CLR)
   ) dut (
      .CLK      (CLK),
      .RESETN   (RESETN),
      .REQ0     (REQ0),
      .REQ1     (REQ1),
      .RS0      (RS0),
      .RS1      (RS1),
      .DATA0    (DATA0),
      .DATA1    (DATA1),
      .ACK0     (ACK0),
      .ACK1     (ACK1),
      .READY    (READY),
      .BUSY     (BUSY),
      .LCD_E    (LCD_E),
      .LCD_RS   (LCD_RS),
      .LCD_RW   (LCD_RW),
      .LCD_DATA (LCD_DATA),
      .dbg_state(dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] init_byte(input int i);
      case (i)
         0:       return 8'h3C;
         1:       return 8'h0C;
         2:       return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   function automatic int write_len(input logic rs, input logic [7:0] d);
      return (!rs && (d == 8'h01 || d == 8'h02)) ? W_CLR : W_NORM;
   endfunction

   // Timeline model: every write is a window [start, start+len) measured in
   // cycles since reset release; outputs follow from the offset in the window.
   int         m_k, m_ws, m_wl, m_who, m_i, m_off;
   logic       m_rr, m_wv, m_prev_idle, m_rs;
   logic [7:0] m_data;
   logic       x_ack0, x_ack1, x_ready, x_busy, x_e, x_rs;
   logic [7:0] x_data;

   // scoreboard: one packed compare of all outputs per cycle
   always @(posedge CLK) begin
      #1;
      if (!RESETN) begin
         m_k = 0; m_rr = 1'b0; m_wv = 1'b0; m_prev_idle = 1'b0;
         m_rs = 1'b0; m_data = 8'h00;
         x_ack0 = 1'b0; x_ack1 = 1'b0; x_ready = 1'b0; x_busy = 1'b1;
         x_e = 1'b0; x_rs = 1'b0; x_data = 8'h00;
      end else begin
         m_k++;
         x_ack0 = 1'b0; x_ack1 = 1'b0;
         if (m_k < T_PWR) begin
            x_ready = 1'b0; x_busy = 1'b1; x_e = 1'b0; x_rs = 1'b0; x_data = 8'h00;
            m_prev_idle = 1'b0;
         end else if (m_k < READY_K) begin
            m_i = (m_k - T_PWR) / W_NORM;
            if (m_i > 3) m_i = 3;
            m_off  = m_k - (T_PWR + m_i * W_NORM);
            m_rs   = 1'b0;
            m_data = init_byte(m_i);
            x_ready = 1'b0; x_busy = 1'b1;
            x_e = (m_off >= 1 && m_off <= T_E);
            x_rs = 1'b0; x_data = m_data;
            m_prev_idle = 1'b0;
         end else begin
            if (m_prev_idle && (REQ0 || REQ1)) begin
               m_who  = (REQ0 && REQ1) ? int'(m_rr) : (REQ1 ? 1 : 0);
               m_rr   = (m_who == 0);
               m_rs   = (m_who == 1) ? RS1 : RS0;
               m_data = (m_who == 1) ? DATA1 : DATA0;
               m_wv   = 1'b1;
               m_ws   = m_k;
               m_wl   = write_len(m_rs, m_data);
            end
            x_ready = 1'b1; x_rs = m_rs; x_data = m_data;
            if (m_wv && m_k < m_ws + m_wl) begin
               m_off  = m_k - m_ws;
               x_busy = 1'b1;
               x_e    = (m_off >= 1 && m_off <= T_E);
               x_ack0 = (m_off == 0) && (m_who == 0);
               x_ack1 = (m_off == 0) && (m_who == 1);
               m_prev_idle = 1'b0;
            end else begin
               m_wv = 1'b0;
               x_busy = 1'b0; x_e = 1'b0;
               m_prev_idle = 1'b1;
            end
         end
      end
      check("cycle_outputs{ack0,ack1,ready,busy,e,rs,rw,data}",
            {ACK0, ACK1, READY, BUSY, LCD_E, LCD_RS, LCD_RW, LCD_DATA},
            {x_ack0, x_ack1, x_ready, x_busy, x_e, x_rs, 1'b0, x_data});
   end

   // driver tasks
   task automatic pick_req(input int who);
      logic       rs;
      logic [7:0] d;
      rs = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom_range(0, 255));
      if (who == 0) begin REQ0 = 1'b1; RS0 = rs; DATA0 = d; end
      else          begin REQ1 = 1'b1; RS1 = rs; DATA1 = d; end
   endtask

   task automatic rand_drive(input bit allow_new);
      if (REQ0 && ACK0) begin
         REQ0 = 1'b0;
         if (allow_new && $urandom_range(0, 1) == 1) pick_req(0);
      end else if (!REQ0 && allow_new && $urandom_range(0, 5) == 0) pick_req(0);
      if (REQ1 && ACK1) begin
         REQ1 = 1'b0;
         if (allow_new && $urandom_range(0, 1) == 1) pick_req(1);
      end else if (!REQ1 && allow_new && $urandom_range(0, 5) == 0) pick_req(1);
   endtask

   // Called on the release negedge; watches the init pulses until READY.
   task automatic init_watch(output int j);
      int         e_run;
      logic [7:0] e_data;
      exp_q = '{8'h3C, 8'h0C, 8'h06, 8'h01};
      j = 0; e_run = 0; e_data = 8'h00;
      while (!READY && j < 2000) begin
         @(negedge CLK);
         j++;
         if (ACK0 || ACK1) check("no_ack_before_ready", {ACK0, ACK1}, 2'b00);
         if (LCD_E) begin
            e_run++;
            e_data = LCD_DATA;
         end else if (e_run > 0) begin
            check("init_e_width", e_run, 4);
            check("init_pulse_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("init_byte", e_data, exp_q.pop_front());
            e_run = 0;
         end
      end
      check("ready_cycle", j, 384);
      check("init_pulses_left", exp_q.size(), 0);
   endtask

   // Called on the negedge of the ACK cycle; ends on the first idle negedge.
   task automatic measure_write(output int busy_n, output int e_n, output int ack_n,
                                output bit stable);
      logic       rs0;
      logic [7:0] d0;
      rs0 = LCD_RS; d0 = LCD_DATA;
      busy_n = 0; e_n = 0; ack_n = 0; stable = 1'b1;
      while (BUSY && busy_n < 1000) begin
         busy_n++;
         if (LCD_E) e_n++;
         if (ACK0 || ACK1) ack_n++;
         if (LCD_RS !== rs0 || LCD_DATA !== d0) stable = 1'b0;
         @(negedge CLK);
      end
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      while (BUSY && c < budget) begin @(negedge CLK); c++; end
      check("idle_reached", BUSY, 1'b0);
   endtask

   int         j, busy_n, e_n, ack_n, cyc, n, c;
   bit         stable;
   int         ack_who[$];
   int         ack_cyc[$];
   logic [7:0] ack_dat[$];

   initial begin
      RESETN = 1'b0;
      REQ0 = 1'b0; REQ1 = 1'b0; RS0 = 1'b0; RS1 = 1'b0; DATA0 = 8'h00; DATA1 = 8'h00;
      repeat (3) @(negedge CLK);
      check("rst_e", LCD_E, 1'b0);
      check("rst_ready", READY, 1'b0);
      check("rst_busy", BUSY, 1'b1);
      check("rst_bus", {LCD_RS, LCD_RW, LCD_DATA}, 10'h000);
      check("rst_acks", {ACK0, ACK1}, 2'b00);

      // power-on init with no requests
      RESETN = 1'b1;
      init_watch(j);

      // single data write from requester 0
      REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h41;
      @(negedge CLK);
      check("w0_ack_latency", ACK0, 1'b1);
      REQ0 = 1'b0;
      measure_write(busy_n, e_n, ack_n, stable);
      check("w0_busy_len", busy_n, 36);
      check("w0_e_len", e_n, 4);
      check("w0_ack_pulses", ack_n, 1);
      check("w0_bus_stable", stable, 1'b1);
      check("w0_bus_value", {LCD_RS, LCD_DATA}, 9'h141);

      // clear command from requester 1: long settle
      REQ1 = 1'b1; RS1 = 1'b0; DATA1 = 8'h01;
      @(negedge CLK);
      check("clr_ack", ACK1, 1'b1);
      REQ1 = 1'b0;
      measure_write(busy_n, e_n, ack_n, stable);
      check("clr_busy_len", busy_n, 206);
      check("clr_e_len", e_n, 4);
      check("clr_bus_stable", stable, 1'b1);

      // same byte as data: short settle
      REQ1 = 1'b1; RS1 = 1'b1; DATA1 = 8'h01;
      @(negedge CLK);
      check("d01_ack", ACK1, 1'b1);
      REQ1 = 1'b0;
      measure_write(busy_n, e_n, ack_n, stable);
      check("d01_busy_len", busy_n, 36);

      // both held: last grant was requester 1, so 0,1,0,1,0 with tight spacing
      REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h41;
      REQ1 = 1'b1; RS1 = 1'b1; DATA1 = 8'h42;
      cyc = 0; n = 0;
      while (n < 5 && cyc < 1000) begin
         @(negedge CLK);
         cyc++;
         if (ACK0) begin ack_who.push_back(0); ack_cyc.push_back(cyc); ack_dat.push_back(LCD_DATA); n++; end
         if (ACK1) begin ack_who.push_back(1); ack_cyc.push_back(cyc); ack_dat.push_back(LCD_DATA); n++; end
         if (n == 4) REQ1 = 1'b0;
         if (n == 5) REQ0 = 1'b0;
      end
      check("rr_ack_count", ack_who.size(), 5);
      for (int i = 0; i < 5 && i < ack_who.size(); i++) begin
         check($sformatf("rr_order_%0d", i), ack_who[i], (i % 2 == 0) ? 0 : 1);
         check($sformatf("rr_data_%0d", i), ack_dat[i], (i % 2 == 0) ? 8'h41 : 8'h42);
         if (i > 0) check($sformatf("rr_gap_%0d", i), ack_cyc[i] - ack_cyc[i-1], 37);
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      wait_idle(300);

      // random traffic against the timeline model
      for (int i = 0; i < 2500; i++) begin
         @(negedge CLK);
         rand_drive(1'b1);
      end
      c = 0;
      while ((REQ0 || REQ1 || BUSY) && c < 3000) begin
         @(negedge CLK);
         rand_drive(1'b0);
         c++;
      end
      check("drain_done", {REQ0, REQ1, BUSY}, 3'b000);

      // reset while E is high, then a request held across the whole re-init
      @(negedge CLK);
      REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h55;
      @(negedge CLK);
      check("pre_rst_ack", ACK0, 1'b1);
      REQ0 = 1'b0;
      c = 0;
      while (!LCD_E && c < 20) begin @(negedge CLK); c++; end
      check("pre_rst_e_high", LCD_E, 1'b1);
      @(posedge CLK);
      #3;
      RESETN = 1'b0;
      #1;
      check("async_rst_e", LCD_E, 1'b0);
      check("async_rst_ready", READY, 1'b0);
      check("async_rst_busy", BUSY, 1'b1);
      check("async_rst_bus", {ACK0, ACK1, LCD_RS, LCD_DATA}, 11'h000);
      repeat (3) @(negedge CLK);
      RESETN = 1'b1;
      REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h66;
      init_watch(j);
      @(negedge CLK);
      check("held_req_ack_after_ready", ACK0, 1'b1);
      check("held_req_data", {LCD_RS, LCD_DATA}, 9'h166);
      REQ0 = 1'b0;
      wait_idle(100);
      repeat (2) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // run-time bound
   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
